tx_fifo_wr_arbiter: RTL

TX_FIFO_WR_ARBITER -- requirements
Module: tx_fifo_wr_arbiter

---
 rtl/tx_fifo_arb_pkg.sv | 17 +
 rtl/tx_arb_rr_pick.sv | 24 ++
 rtl/tx_fifo_wr_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/tx_fifo_arb_pkg.sv
// Shared types and default sizing for the TX FIFO write arbiter.
package tx_fifo_arb_pkg;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_BURST = 16;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_arb_rr_pick.sv
// Round-robin picker: one-hot first requester after last_owner, with wrap.
module tx_arb_rr_pick
  import tx_fifo_arb_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_owner,
  output logic [N_REQ-1:0] pick
);

  logic [IW:0]        shift;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   rot_first;

  // Rotate so bit 0 is the requester right after last_owner, take the lowest
  // set bit, then rotate back.
  assign shift     = {1'b0, last_owner} + (IW+1)'(1);
  assign rot       = N_REQ'({req, req} >> shift);
  assign rot_first = rot & (~rot + N_REQ'(1));
  assign pick      = N_REQ'(({rot_first, rot_first} << shift) >> N_REQ);

endmodule

// File: rtl/tx_fifo_wr_arbiter.sv
// Burst-granting round-robin arbiter that merges N_REQ beat streams into one
// FIFO write port, honouring FIFO back-pressure.
module tx_fifo_wr_arbiter
  import tx_fifo_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ack,
  output logic [N_REQ-1:0]        grant,
  output logic [DATA_W-1:0]       fifo_wr_data,
  output logic                    fifo_wr_en,
  input  logic                    fifo_wr_vld,
  output logic                    busy
);

  localparam int IW = idx_w(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0] OWNER_RST = IW'(N_REQ - 1);

  arb_state_e       state_reg;
  logic [N_REQ-1:0] grant_reg;
  logic [IW-1:0]    last_owner_reg;
  logic [CW-1:0]    cnt_reg;

  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    owner_idx;
  logic             owner_req;
  logic             owner_last;
  logic             burst_done;
  logic [DATA_W-1:0] data_terms [N_REQ];

  tx_arb_rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req        (req),
    .last_owner (last_owner_reg),
    .pick       (pick)
  );

  // grant_reg is all-zero in IDLE, so every owner-qualified term below is 0 there.
  assign owner_req  = |(req & grant_reg);
  assign owner_last = |(req_last & grant_reg);
  assign fifo_wr_en = owner_req & fifo_wr_vld;
  assign req_ack    = grant_reg & {N_REQ{fifo_wr_en}};
  assign grant      = grant_reg;
  assign busy       = (state_reg == XFER);
  assign burst_done = (fifo_wr_en & (owner_last | (cnt_reg == CNT_LAST))) | ~owner_req;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_data_mux
      assign data_terms[gi] = req_data[gi*DATA_W +: DATA_W] & {DATA_W{grant_reg[gi]}};
    end
  endgenerate

  always_comb begin
    fifo_wr_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      fifo_wr_data = fifo_wr_data | data_terms[i];
    end
  end

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_reg[i]) begin
        owner_idx = owner_idx | IW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_owner_reg <= OWNER_RST;
      cnt_reg        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req) begin
            grant_reg <= pick;
            cnt_reg   <= '0;
            state_reg <= XFER;
          end
        end
        XFER: begin
          if (fifo_wr_en) begin
            cnt_reg <= cnt_reg + CW'(1);
          end
          // Normal end and abandon share one exit path.
          if (burst_done) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_owner_reg <= owner_idx;
          end
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= '0;
        end
      endcase
    end
  end

endmodule
